fifo_rd_packer: RTL and testbench

Read-side consumer for the team's dual-clock FIFO, running entirely in the FIFO read clock domain. It drains the FIFO's fall-through read port (`rempty`/`rinc`/`rdata`) and packs PACK consecutive DSIZE-bit words into one wide output beat. The output uses a valid/ready handshake toward downstream logic such as a DMA or bus master. An optional idle-timeout flush emits partially filled beats with a lane-keep mask.

---
 rtl/fifo_rd_packer.sv | 143 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer
// Description : Drains a fall-through FIFO read port and packs PACK words per
//               valid/ready output beat. Optional idle-timeout flush of partial
//               beats when FIFO_RD_PACKER_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4,
    parameter int TMO   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_valid,
    input  logic                  m_ready
);
    localparam int CW = $clog2(PACK);
    localparam int AW = DSIZE * (PACK - 1);
    localparam logic [CW-1:0] C_LAST = CW'(PACK - 1);

    if (PACK < 2 || PACK > 16 || TMO < 1 || TMO > 255) begin : g_param_check
        $error("fifo_rd_packer: PACK must be 2..16 and TMO 1..255");
    end

    logic [AW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         acc_cnt_q, acc_cnt_d;
    logic [DSIZE*PACK-1:0] m_data_q, m_data_d;
    logic [PACK-1:0]       m_keep_q, m_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic                  w_out_free;
    logic                  w_full;
    logic                  w_pop;

    assign w_out_free = !m_valid_q || m_ready;
    assign w_full     = (acc_cnt_q == C_LAST);
    // The final word of a beat may only be popped if the output stage can take it.
    assign w_pop      = !rempty && (!w_full || w_out_free);

`ifdef FIFO_RD_PACKER_FLUSH_EN
    localparam int IW = $clog2(TMO + 1);
    localparam logic [IW-1:0] C_TMO = IW'(TMO);

    logic [IW-1:0]         idle_q, idle_d;
    logic                  w_flush;
    logic [DSIZE*PACK-1:0] w_flush_data;
    logic [PACK-1:0]       w_flush_keep;

    assign w_flush = !w_pop && (idle_q == C_TMO) && (acc_cnt_q != '0) && w_out_free;

    always_comb begin
        w_flush_data = '0;
        w_flush_keep = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            if (CW'(i) < acc_cnt_q) begin
                w_flush_data[i*DSIZE +: DSIZE] = acc_q[i*DSIZE +: DSIZE];
                w_flush_keep[i]                = 1'b1;
            end
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (w_pop || (acc_cnt_q == '0) || w_flush) begin
            idle_d = '0;
        end else if (idle_q != C_TMO) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    always_comb begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_valid_d = m_valid_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (w_pop) begin
            if (w_full) begin
                // A load overrides the acceptance clear, giving bubble-free beats.
                m_data_d  = {rdata, acc_q};
                m_keep_d  = '1;
                m_valid_d = 1'b1;
                acc_cnt_d = '0;
            end else begin
                for (int i = 0; i < PACK - 1; i++) begin
                    if (acc_cnt_q == CW'(i)) begin
                        acc_d[i*DSIZE +: DSIZE] = rdata;
                    end
                end
                acc_cnt_d = acc_cnt_q + 1'b1;
            end
        end
`ifdef FIFO_RD_PACKER_FLUSH_EN
        else if (w_flush) begin
            m_data_d  = w_flush_data;
            m_keep_d  = w_flush_keep;
            m_valid_d = 1'b1;
            acc_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign rinc    = w_pop;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_valid = m_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_packer
// Description : Self-checking bench for fifo_rd_packer: vector table, directed
//               corner sequences and a randomized word-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;
    localparam int DSIZE = 8;
    localparam int PACK  = 4;
    localparam int TMO   = 16;
    localparam int DW    = DSIZE * PACK;

    logic              clk = 1'b0;
    logic              rst;
    logic              rempty;
    logic [DSIZE-1:0]  rdata;
    logic              rinc;
    logic [DW-1:0]     m_data;
    logic [PACK-1:0]   m_keep;
    logic              m_valid;
    logic              m_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK), .TMO(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    typedef struct {
        logic             rempty;
        logic [DSIZE-1:0] rdata;
        logic             ready;
        logic             rinc;
        logic             valid;
        logic [DW-1:0]    data;
        logic [PACK-1:0]  keep;
    } vec_t;

    vec_t vt[10];

    // Source FIFO model and expected word stream.
    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];
    bit               gate_empty;
    int               beats;
    int               pops;
    logic [DW-1:0]    last_beat;
    logic [PACK-1:0]  last_keep;
    logic             last_rinc;
    bit               hold_pending;
    logic [DW-1:0]    hold_data;
    logic [PACK-1:0]  hold_keep;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drive_fifo();
        rempty = (fifo_q.size() == 0) || gate_empty;
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic score(input logic [DW-1:0] d, input logic [PACK-1:0] k);
        int n;
        logic [PACK-1:0] ek;
        n  = 0;
        ek = '0;
        beats++;
        last_beat = d;
        last_keep = k;
        while (n < PACK && k[n] == 1'b1) begin
            ek[n] = 1'b1;
            n++;
        end
        chk("keep_contiguous", k, ek);
`ifndef FIFO_RD_PACKER_FLUSH_EN
        chk("keep_full", k, {PACK{1'b1}});
`endif
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_word: got 0x%0h, expected no word", d[i*DSIZE +: DSIZE]);
            end else begin
                chk("beat_word", d[i*DSIZE +: DSIZE], exp_q.pop_front());
            end
        end
        for (int i = n; i < PACK; i++) begin
            chk("beat_upper_zero", d[i*DSIZE +: DSIZE], 0);
        end
    endtask

    // One clock of FIFO-driven operation; outputs sampled on the falling edge.
    task automatic cycle();
        logic          r_s, v_s, rdy_s, e_s;
        logic [DW-1:0] d_s;
        logic [PACK-1:0] k_s;
        drive_fifo();
        @(negedge clk);
        r_s = rinc; v_s = m_valid; rdy_s = m_ready; d_s = m_data; k_s = m_keep; e_s = rempty;
        last_rinc = r_s;
        if (e_s) chk("rinc_while_empty", r_s, 0);
        if (hold_pending) begin
            chk("stall_valid", v_s, 1);
            chk("stall_data", d_s, hold_data);
            chk("stall_keep", k_s, hold_keep);
        end
        @(posedge clk);
        #1;
        if (r_s && !e_s) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (v_s && rdy_s) score(d_s, k_s);
        hold_pending = v_s && !rdy_s;
        hold_data    = d_s;
        hold_keep    = k_s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        gate_empty   = 1'b0;
        m_ready      = 1'b0;
        hold_pending = 1'b0;
        beats        = 0;
        pops         = 0;
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rempty  = 1'b1;
        rdata   = '0;
        m_ready = 1'b0;
        gate_empty = 1'b0;
        hold_pending = 1'b0;

        //           rempty rdata  rdy  rinc valid data          keep
        vt[0] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
        vt[1] = '{1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
        vt[2] = '{1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
        vt[3] = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
        vt[4] = '{1'b0, 8'h05, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF};
        vt[5] = '{1'b0, 8'h06, 1'b1, 1'b1, 1'b0, 32'h04030201, 4'hF};
        vt[6] = '{1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 32'h04030201, 4'hF};
        vt[7] = '{1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 32'h04030201, 4'hF};
        vt[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 32'h08070605, 4'hF};
        vt[9] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h08070605, 4'hF};

        // Reset state
        @(negedge clk);
        chk("reset_valid", m_valid, 0);
        chk("reset_data", m_data, 0);
        chk("reset_keep", m_keep, 0);
        chk("reset_rinc", rinc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table: 8 words, downstream always ready
        for (int i = 0; i < 10; i++) begin
            rempty  = vt[i].rempty;
            rdata   = vt[i].rdata;
            m_ready = vt[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d_rinc", i), rinc, vt[i].rinc);
            chk($sformatf("vec%0d_valid", i), m_valid, vt[i].valid);
            chk($sformatf("vec%0d_data", i), m_data, vt[i].data);
            chk($sformatf("vec%0d_keep", i), m_keep, vt[i].keep);
            @(posedge clk);
            #1;
        end

        // Stall with 10 words queued, then back-to-back release
        do_reset();
        for (int i = 0; i < 10; i++) push(8'(8'h11 + i));
        repeat (12) cycle();
        chk("stall_pops", pops, 7);
        chk("stall_rinc_low", last_rinc, 0);
        chk("stall_beat_valid", m_valid, 1);
        chk("stall_beat_data", m_data, 32'h14131211);
        m_ready = 1'b1;
        cycle();
        chk("b2b_beats", beats, 1);
        chk("b2b_valid", m_valid, 1);
        chk("b2b_data", m_data, 32'h18171615);
        repeat (10) cycle();
        chk("release_beats", beats, 2);
        chk("release_fifo_empty", fifo_q.size(), 0);
        chk("release_acc_words", exp_q.size(), 2);

        // Idle partial beat
        do_reset();
        m_ready = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (30) cycle();
`ifdef FIFO_RD_PACKER_FLUSH_EN
        chk("flush_beats", beats, 1);
        chk("flush_data", last_beat, 32'h00A3A2A1);
        chk("flush_keep", last_keep, 4'h7);
`else
        chk("noflush_beats", beats, 0);
        chk("noflush_valid", m_valid, 0);
        chk("noflush_words_pending", exp_q.size(), 3);
`endif

        // Reset in the middle of a beat
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'hC1 + i));
        cycle();
        cycle();
        chk("midrst_pops", pops, 2);
        #2;
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        hold_pending = 1'b0;
        drive_fifo();
        #1;
        chk("midrst_valid", m_valid, 0);
        chk("midrst_data", m_data, 0);
        chk("midrst_keep", m_keep, 0);
        chk("midrst_rinc", rinc, 0);
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", m_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'hB1 + i));
        repeat (8) cycle();
        chk("postrst_beats", beats, 1);
        chk("postrst_beat", last_beat, 32'hB4B3B2B1);

        // Randomized traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if (($urandom % 4) != 0 && fifo_q.size() < 16) push(8'($urandom));
            gate_empty = (($urandom % 5) == 0);
            m_ready    = (($urandom % 3) != 0);
            cycle();
        end
        gate_empty = 1'b0;
        m_ready    = 1'b1;
        repeat (40) cycle();
        chk("drain_fifo_empty", fifo_q.size(), 0);
        chk("drain_valid_low", m_valid, 0);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        chk("drain_no_leftover", exp_q.size(), 0);
`else
        chk("drain_leftover_lt_pack", (exp_q.size() < PACK), 1);
`endif
        chk("random_beats_seen", (beats > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
